// File: rtl/uart_tx_if.sv
// Host-side byte handshake plus serial line and status for uart_tx.
// master = host/FIFO side, slave = transmitter side.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_serial, tx_busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_serial, tx_busy
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, serialised LSB-first
// at CLK_FREQ/BAUD_RATE clocks per bit. All outputs come straight from flops.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic     clk,
  input  logic     rst_,
  uart_tx_if.slave bus
);
  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

  generate
    if (DIVISOR < 2) begin : g_div_chk
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          ser_q, ser_nxt;
  logic          rdy_q, busy_q;
  logic          accept, bit_end;

  assign accept        = bus.tx_valid && rdy_q;
  assign bit_end       = (cnt == CNT_LAST);
  assign bus.tx_serial = ser_q;
  assign bus.tx_ready  = rdy_q;
  assign bus.tx_busy   = busy_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ser_q   <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      ser_q   <= ser_nxt;
      rdy_q   <= (state_nxt == IDLE);
      busy_q  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_end ? '0 : cnt + CW'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          shreg_nxt = bus.tx_data;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_nxt   = {1'b0, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is decoded from the next state so the flop already holds it
    // in the first cycle of each bit.
    unique case (state_nxt)
      START:   ser_nxt = 1'b0;
      DATA:    ser_nxt = shreg_nxt[0];
      default: ser_nxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line check against a frame model at DIVISOR=10,
// plus a sampling receiver on a default-rate instance.
module tb_uart_tx;
  localparam int D  = 10;
  localparam int D2 = 50_000_000 / 115200;
  localparam int NLB = 6;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if bus ();
  uart_tx_if bus2 ();

  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (.clk(clk), .rst_(rst_), .bus(bus));
  uart_tx dut2 (.clk(clk), .rst_(rst_), .bus(bus2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame = start(0), 8 data bits LSB first, stop(1); each bit lasts d cycles.
  function automatic logic line_bit(input logic [7:0] b, input int c, input int d);
    int k;
    k = c / d;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic idle_check(input string tag);
    chk({tag, "_ser"},   32'(bus.tx_serial), 32'd1);
    chk({tag, "_ready"}, 32'(bus.tx_ready),  32'd1);
    chk({tag, "_busy"},  32'(bus.tx_busy),   32'd0);
  endtask

  // Called at a negedge with the DUT idle; checks the first ncyc frame cycles.
  task automatic send_frame(input logic [7:0] b, input int ncyc, input bit hold,
                            input bit noise, output int t0);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    if (!hold) bus.tx_valid = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("ser_%02h_c%0d", b, c), 32'(bus.tx_serial), 32'(line_bit(b, c, D)));
      chk("ready_frame", 32'(bus.tx_ready), 32'd0);
      chk("busy_frame",  32'(bus.tx_busy),  32'd1);
      if (noise && $urandom_range(0, 5) == 0) begin
        bus.tx_valid = 1'($urandom_range(0, 1));
        bus.tx_data  = 8'h3C ^ 8'($urandom_range(0, 255));
      end
      if (hold) bus.tx_data = 8'($urandom_range(0, 255));
    end
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  // Sampling receiver for the default-rate instance: mid-bit samples.
  logic [7:0] rxq[$];
  logic [7:0] exq[$];
  logic [9:0] rx_f;
  int rx_err = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus2.tx_serial === 1'b0) begin
        repeat (D2 / 2) @(negedge clk);
        rx_f[0] = bus2.tx_serial;
        for (int k = 1; k < 10; k++) begin
          repeat (D2) @(negedge clk);
          rx_f[k] = bus2.tx_serial;
        end
        if (rx_f[0] !== 1'b0 || rx_f[9] !== 1'b1) rx_err++;
        rxq.push_back(rx_f[8:1]);
      end
    end
  end

  initial begin
    int t0, t1, w;
    logic [7:0] b;
    bus.tx_valid  = 1'b1;
    bus.tx_data   = 8'h55;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;

    // Reset held with tx_valid high: nothing may be accepted.
    rst_ = 1'b1;
    repeat (3) begin
      @(negedge clk);
      idle_check("rst");
    end
    rst_ = 1'b0;
    send_frame(8'h55, 10*D, 1'b0, 1'b0, t0);
    @(negedge clk);
    idle_check("post_rst");

    // Single frame 0xA5.
    send_frame(8'hA5, 10*D, 1'b0, 1'b0, t0);
    @(negedge clk);
    idle_check("a5_end");
    repeat (3) begin @(negedge clk); idle_check("a5_idle"); end

    // Back-to-back 0x00 then 0xFF with tx_valid held.
    send_frame(8'h00, 10*D, 1'b1, 1'b0, t0);
    @(negedge clk);
    idle_check("b2b_gap");
    send_frame(8'hFF, 10*D, 1'b0, 1'b0, t1);
    chk("b2b_period", 32'(t1 - t0), 32'(10*D + 1));
    @(negedge clk);
    idle_check("b2b_end");

    // Mid-frame valid pulses and data changes are ignored.
    send_frame(8'hC3, 10*D, 1'b0, 1'b1, t0);
    @(negedge clk);
    idle_check("noise_end");
    bus.tx_valid = 1'b0;
    repeat (15) begin @(negedge clk); idle_check("no_second"); end

    // Reset during data bit 3 of 0x0F, with tx_valid high through reset.
    send_frame(8'h0F, 4*D + D/2, 1'b0, 1'b0, t0);
    rst_ = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h99;
    @(negedge clk);
    idle_check("rst_mid");
    @(negedge clk);
    idle_check("rst_accept");
    rst_ = 1'b0;
    send_frame(8'h81, 10*D, 1'b0, 1'b0, t0);
    @(negedge clk);
    idle_check("r81_end");

    // Random frames with random idle gaps and optional noise.
    repeat (12) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 10*D, 1'b0, 1'($urandom_range(0, 1)), t0);
      bus.tx_valid = 1'b0;
      @(negedge clk);
      idle_check("rnd_end");
      repeat ($urandom_range(0, 4)) begin @(negedge clk); idle_check("rnd_gap"); end
    end

    // Default-rate instance decoded by the sampling receiver.
    for (int i = 0; i < NLB; i++) begin
      b = 8'($urandom_range(0, 255));
      w = 0;
      while (bus2.tx_ready !== 1'b1 && w < 12*D2) begin
        @(negedge clk);
        w++;
      end
      chk("lb_ready_timeout", 32'(w >= 12*D2), 32'd0);
      bus2.tx_data  = b;
      bus2.tx_valid = 1'b1;
      @(negedge clk);
      bus2.tx_valid = 1'b0;
      exq.push_back(b);
    end
    repeat (11*D2) @(negedge clk);
    chk("lb_count", 32'(rxq.size()), 32'(NLB));
    for (int i = 0; i < NLB; i++)
      chk($sformatf("lb_byte%0d", i), (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, 32'(exq[i]));
    chk("lb_frame_err", 32'(rx_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, 8N1 (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity). Transmit-side counterpart of uart_rx; same CLK_FREQ/BAUD_RATE parameterisation.
- Accepts one byte per valid/ready handshake from the local fabric and serialises it onto tx_serial at BAUD_RATE.
- Sits between host logic (or a TX FIFO) and the pad. Pairs with uart_rx for loopback verification.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- DIVISOR (localparam), CLK_FREQ/BAUD_RATE (integer truncation; 434 at defaults), clk cycles per bit. DIVISOR >= 2 is required; elaboration-time assertion otherwise.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_  input  1  reset, synchronous, active-high (rst_=1 resets on the next posedge).
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx_valid  input  1  host has a byte on tx_data.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx_serial  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress (any state other than IDLE).

Behaviour:
- Reset values (registered): tx_serial=1, tx_ready=1, tx_busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- Accept: the handshake completes on the posedge where tx_valid && tx_ready. tx_data is latched into the shift register, and the FSM moves IDLE->START.
  - tx_valid without tx_ready: ignored, no queuing. The host must hold tx_valid and tx_data until ready.
  - tx_data changes after accept: no effect on the frame in flight.
- Outputs are registered. In the cycle after accept: tx_serial=0, tx_ready=0, tx_busy=1.
- Baud counter:
  - counts 0..DIVISOR-1 within each bit period;
  - wraps to 0 at DIVISOR-1;
  - the bit period ends on wrap.
  - Width is $clog2(DIVISOR).
- FSM:
  - IDLE: tx_serial=1, tx_ready=1, counter held at 0. Accept -> START.
  - START: tx_serial=0 for DIVISOR cycles -> DATA, bit index=0.
  - DATA: tx_serial = shift register bit 0 for DIVISOR cycles per bit. At each bit end, shift right by 1 and increment the bit index. At the end of index 7 -> STOP.
  - STOP: tx_serial=1 for DIVISOR cycles -> IDLE.
- Frame timing:
  - The frame occupies exactly 10*DIVISOR cycles from the first low cycle to the last stop cycle.
  - tx_ready reasserts in the first IDLE cycle after STOP.
  - The earliest next accept is that cycle, so back-to-back frames are separated by exactly 1 idle-high cycle. Period is 10*DIVISOR+1 cycles.
- tx_busy = (state != IDLE). tx_ready = (state == IDLE). They are never both 1, and never both 0 outside reset.
- tx_serial must be glitch-free: driven from a flop, never combinationally from state.
- Reset mid-frame: on the reset posedge the frame is abandoned and all outputs return to reset values. tx_serial goes high immediately, so the receiver sees a framing error. tx_valid asserted during reset is not accepted.
- Reset and accept on the same cycle: reset wins, and the byte is dropped.

Test Plan:
- Reset: hold rst_=1 for 3 cycles with tx_valid=1, then release -> tx_serial=1, tx_ready=1, tx_busy=0 throughout. No frame starts until the first posedge with rst_=0 and tx_valid=1.
- Single frame: CLK_FREQ=1000, BAUD_RATE=100 (DIVISOR=10), send 0xA5 -> tx_serial is low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. tx_ready is low for exactly 100 cycles.
- Back-to-back: hold tx_valid=1 with 0x00 then 0xFF -> the second start bit begins exactly 101 cycles after the first. There is exactly 1 high cycle between stop and start, and 0x00 shows 9 consecutive low bit-periods.
- Hold and ignore: pulse tx_valid mid-frame with 0x3C while busy -> no effect on the current frame, and no second frame. Change tx_data mid-frame -> the line matches the original byte.
- Reset mid-frame: assert rst_ during data bit 3 of 0x0F -> tx_serial=1 and tx_ready=1 on the next cycle. A new 0x81 frame then transmits correctly.
- Loopback at defaults (DIVISOR=434): connect tx_serial to uart_rx and send 256 random bytes -> rx_data matches the reference queue in order. rx_valid fires once per byte, and rx_error is never asserted.
